// File: rtl/cic_integ_decim.sv
// CIC decimator front end: a cascade of wrapping integrators plus the frame
// counter that picks one integrated sample out of every R accepted samples.
// The comb section downstream relies on modulo-2^OUT_WIDTH wrap, so no
// saturation or overflow detection is done here.
module cic_integ_decim #(
   parameter int IN_WIDTH   = 5,
   parameter int NUM_STAGES = 1,
   parameter int OUT_WIDTH  = 48,
   parameter int RATE_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  sync_reset_n,
   input  logic [RATE_WIDTH-1:0] rate,
   input  logic                  s_axis_tvalid,
   input  logic [IN_WIDTH-1:0]   s_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic [OUT_WIDTH-1:0]  m_axis_tdata,
   output logic                  frame_start
);

   logic                  accept;
   logic [RATE_WIDTH-1:0] rate_eff;
   logic [RATE_WIDTH-1:0] r_latched;
   logic [RATE_WIDTH-1:0] r_frame;
   logic [RATE_WIDTH-1:0] cnt;
   logic                  frame_first;
   logic                  frame_last;
   logic [OUT_WIDTH-1:0]  sample_ext;

   logic [OUT_WIDTH-1:0]  acc [NUM_STAGES];
   logic [NUM_STAGES-1:0] valid_pipe;
   logic [NUM_STAGES-1:0] tag_pipe;

   // A sample is taken only outside reset, so tvalid during reset is ignored.
   // The first sample of a frame uses the incoming rate, since that is the
   // value being latched on this very cycle; later samples use the latch.
   always_comb begin
      accept      = sync_reset_n && s_axis_tvalid;
      rate_eff    = (rate == '0) ? RATE_WIDTH'(1) : rate;
      frame_first = (cnt == '0);
      r_frame     = frame_first ? rate_eff : r_latched;
      frame_last  = (cnt == (r_frame - RATE_WIDTH'(1)));
      frame_start = accept && frame_first;
      sample_ext  = {{(OUT_WIDTH-IN_WIDTH){s_axis_tdata[IN_WIDTH-1]}}, s_axis_tdata};
   end

   // Frame counter and rate latch; the rate is captured only on a frame's
   // first sample so a mid-frame change waits for the next frame.
   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         cnt       <= '0;
         r_latched <= RATE_WIDTH'(1);
      end else if (accept) begin
         if (frame_first) begin
            r_latched <= rate_eff;
         end
         cnt <= frame_last ? '0 : (cnt + RATE_WIDTH'(1));
      end
   end

   // Integrator cascade: stage 0 adds the new sample, stage k adds the value
   // stage k-1 produced one cycle earlier, gated by the matching valid bit so
   // input gaps stall integration while data already in flight keeps moving.
   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            acc[k] <= '0;
         end
         valid_pipe <= '0;
         tag_pipe   <= '0;
      end else begin
         if (accept) begin
            acc[0] <= acc[0] + sample_ext;
         end
         for (int k = 1; k < NUM_STAGES; k++) begin
            if (valid_pipe[k-1]) begin
               acc[k] <= acc[k] + acc[k-1];
            end
         end
         valid_pipe[0] <= accept;
         tag_pipe[0]   <= accept && frame_last;
         for (int k = 1; k < NUM_STAGES; k++) begin
            valid_pipe[k] <= valid_pipe[k-1];
            tag_pipe[k]   <= tag_pipe[k-1];
         end
      end
   end

   // Output register: one pulse per frame once the tagged sample has passed
   // the last integrator; the data word holds its value between pulses.
   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
      end else begin
         m_axis_tvalid <= tag_pipe[NUM_STAGES-1];
         if (tag_pipe[NUM_STAGES-1]) begin
            m_axis_tdata <= acc[NUM_STAGES-1];
         end
      end
   end

endmodule

// File: tb/tb_cic_integ_decim.sv
// Directed bench for the CIC integrator/decimator: a single-stage instance
// for the hand-computed scenarios and a three-stage, rate-256 instance
// checked against a sample-by-sample reference model.
module tb_cic_integ_decim;

   logic        clk = 1'b0;
   logic        sync_reset_n = 1'b0;
   logic [8:0]  rate = 9'd4;
   logic        s_axis_tvalid = 1'b0;
   logic [4:0]  s_axis_tdata = '0;

   logic        out1_valid;
   logic [47:0] out1_data;
   logic        fs1;
   logic        out3_valid;
   logic [47:0] out3_data;
   logic        fs3;

   int tests_run = 0;
   int tests_failed = 0;

   cic_integ_decim #(.IN_WIDTH(5), .NUM_STAGES(1), .OUT_WIDTH(48), .RATE_WIDTH(9)) dut1 (
      .clk(clk), .sync_reset_n(sync_reset_n), .rate(rate),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
      .m_axis_tvalid(out1_valid), .m_axis_tdata(out1_data), .frame_start(fs1));

   cic_integ_decim #(.IN_WIDTH(5), .NUM_STAGES(3), .OUT_WIDTH(48), .RATE_WIDTH(9)) dut3 (
      .clk(clk), .sync_reset_n(sync_reset_n), .rate(rate),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
      .m_axis_tvalid(out3_valid), .m_axis_tdata(out3_data), .frame_start(fs3));

   always #5 clk = ~clk;

   // Present one input for one cycle; frame_start is sampled before the edge,
   // outputs are left to be sampled 1 ns after the edge by the caller.
   task automatic step(input logic v, input logic [4:0] d, output logic fs);
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      #1;
      fs = fs1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sync_reset_n  = 1'b0;
      s_axis_tvalid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      sync_reset_n  = 1'b1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic test_reset();
      sync_reset_n  = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 5'd7;
      rate          = 9'd4;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (out1_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_valid: got %b expected 0", out1_valid);
      end
      tests_run++;
      if (out1_data !== 48'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_data: got %0d expected 0", out1_data);
      end
      tests_run++;
      if (fs1 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_frame_start: got %b expected 0", fs1);
      end
      tests_run++;
      if (out3_data !== 48'd0 || out3_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_dut3: got valid %b data %0d expected 0/0", out3_valid, out3_data);
      end
      sync_reset_n  = 1'b1;
      s_axis_tvalid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         tests_run++;
         if (out1_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle_valid: cycle %0d got %b expected 0", c, out1_valid);
         end
      end
   endtask

   // Rate 4, data 1: outputs 4, 8, 12 two cycles after each 4th sample.
   task automatic test_rate4();
      logic fs;
      logic [47:0] hold;
      logic exp_v;
      do_reset();
      rate = 9'd4;
      hold = '0;
      for (int k = 0; k < 16; k++) begin
         step(1'b1, 5'd1, fs);
         tests_run++;
         if (fs !== (k % 4 == 0)) begin
            tests_failed++;
            $display("[TB] FAIL rate4_frame_start: sample %0d got %b expected %b", k, fs, (k % 4 == 0));
         end
         exp_v = (k >= 4) && (k % 4 == 0);
         if (exp_v) hold = 48'(k);
         tests_run++;
         if (out1_valid !== exp_v || out1_data !== hold) begin
            tests_failed++;
            $display("[TB] FAIL rate4_output: step %0d got %b/%0d expected %b/%0d", k, out1_valid, out1_data, exp_v, hold);
         end
      end
   endtask

   // Rate 1, data -1: an output every cycle, -1, -2, -3, ...
   task automatic test_back_to_back();
      logic fs;
      logic signed [47:0] e;
      do_reset();
      rate = 9'd1;
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 5'h1f, fs);
         tests_run++;
         if (fs !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_frame_start: sample %0d got %b expected 1", k, fs);
         end
         e = -k;
         tests_run++;
         if (out1_valid !== (k >= 1) || out1_data !== e) begin
            tests_failed++;
            $display("[TB] FAIL b2b_output: step %0d got %b/%0d expected %b/%0d", k, out1_valid, $signed(out1_data), (k >= 1), e);
         end
      end
   endtask

   // Rate 0 behaves as rate 1: every sample produces an output.
   task automatic test_rate_zero();
      logic fs;
      do_reset();
      rate = 9'd0;
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 5'd2, fs);
         tests_run++;
         if (out1_valid !== (k >= 1) || out1_data !== 48'(2 * k)) begin
            tests_failed++;
            $display("[TB] FAIL rate0_output: step %0d got %b/%0d expected %b/%0d", k, out1_valid, out1_data, (k >= 1), 2 * k);
         end
      end
   endtask

   // Rate 2, data 3, tvalid toggling: outputs 6, 12, 18 every 4th cycle,
   // then silence once input stops.
   task automatic test_gaps();
      logic fs;
      logic v;
      logic exp_v;
      logic [47:0] hold;
      do_reset();
      rate = 9'd2;
      hold = '0;
      for (int c = 0; c < 18; c++) begin
         v = (c < 12) && (c % 2 == 0);
         step(v, 5'd3, fs);
         tests_run++;
         if (fs !== ((c < 12) && (c % 4 == 0))) begin
            tests_failed++;
            $display("[TB] FAIL gaps_frame_start: cycle %0d got %b", c, fs);
         end
         exp_v = ((c + 1) % 4 == 0) && (c + 1 <= 12);
         if (exp_v) hold = 48'(6 * ((c + 1) / 4));
         tests_run++;
         if (out1_valid !== exp_v || out1_data !== hold) begin
            tests_failed++;
            $display("[TB] FAIL gaps_output: cycle %0d got %b/%0d expected %b/%0d", c, out1_valid, out1_data, exp_v, hold);
         end
      end
   endtask

   // Rate 4 for the first sample, then 2: first frame closes after 4
   // samples, later frames after 2.
   task automatic test_rate_change();
      logic fs;
      logic exp_v;
      logic exp_fs;
      logic [47:0] hold;
      do_reset();
      rate = 9'd4;
      hold = '0;
      for (int c = 0; c < 12; c++) begin
         if (c == 1) rate = 9'd2;
         step(1'b1, 5'd1, fs);
         exp_fs = (c == 0) || (c >= 4 && c % 2 == 0);
         tests_run++;
         if (fs !== exp_fs) begin
            tests_failed++;
            $display("[TB] FAIL ratechg_frame_start: sample %0d got %b expected %b", c, fs, exp_fs);
         end
         exp_v = (c >= 4) && (c % 2 == 0);
         if (exp_v) hold = 48'(c);
         tests_run++;
         if (out1_valid !== exp_v || out1_data !== hold) begin
            tests_failed++;
            $display("[TB] FAIL ratechg_output: step %0d got %b/%0d expected %b/%0d", c, out1_valid, out1_data, exp_v, hold);
         end
      end
   endtask

   // Reset after two samples of a rate-4 frame discards it entirely.
   task automatic test_reset_midframe();
      logic fs;
      logic exp_v;
      logic [47:0] hold;
      do_reset();
      rate = 9'd4;
      for (int c = 0; c < 2; c++) begin
         step(1'b1, 5'd1, fs);
      end
      sync_reset_n = 1'b0;
      step(1'b1, 5'd1, fs);
      tests_run++;
      if (fs !== 1'b0 || out1_valid !== 1'b0 || out1_data !== 48'd0) begin
         tests_failed++;
         $display("[TB] FAIL midreset_clear: got fs %b valid %b data %0d expected 0/0/0", fs, out1_valid, out1_data);
      end
      sync_reset_n = 1'b1;
      hold = '0;
      for (int j = 0; j < 9; j++) begin
         step(1'b1, 5'd1, fs);
         tests_run++;
         if (fs !== (j % 4 == 0)) begin
            tests_failed++;
            $display("[TB] FAIL midreset_frame_start: sample %0d got %b expected %b", j, fs, (j % 4 == 0));
         end
         exp_v = (j >= 4) && (j % 4 == 0);
         if (exp_v) hold = 48'(j);
         tests_run++;
         if (out1_valid !== exp_v || out1_data !== hold) begin
            tests_failed++;
            $display("[TB] FAIL midreset_output: step %0d got %b/%0d expected %b/%0d", j, out1_valid, out1_data, exp_v, hold);
         end
      end
   endtask

   // Three stages, rate 256, random data and tvalid against a mod-2^48
   // reference; output expected 4 cycles after the tagged sample.
   task automatic test_random();
      logic fs;
      logic v;
      logic [4:0] d;
      logic [47:0] x, a1, a2, a3, hold;
      logic tag;
      logic pv [4];
      logic [47:0] pd [4];
      int cnt_m, accepted, cycles, outputs;
      do_reset();
      rate = 9'd256;
      a1 = '0; a2 = '0; a3 = '0; hold = '0;
      cnt_m = 0; accepted = 0; cycles = 0; outputs = 0;
      for (int i = 0; i < 4; i++) begin
         pv[i] = 1'b0;
         pd[i] = '0;
      end
      while (accepted < 10000 && cycles < 40000) begin
         v = ($urandom_range(3) != 0);
         d = 5'($urandom);
         tag = 1'b0;
         if (v) begin
            x = {{43{d[4]}}, d};
            a1 = a1 + x;
            a2 = a2 + a1;
            a3 = a3 + a2;
            tag = (cnt_m == 255);
            cnt_m = (cnt_m == 255) ? 0 : cnt_m + 1;
            accepted++;
         end
         for (int i = 3; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
         end
         pv[0] = tag;
         pd[0] = a3;
         step(v, d, fs);
         cycles++;
         if (pv[3]) begin
            hold = pd[3];
            outputs++;
         end
         tests_run++;
         if (out3_valid !== pv[3] || out3_data !== hold) begin
            tests_failed++;
            $display("[TB] FAIL random_output: cycle %0d got %b/%h expected %b/%h", cycles, out3_valid, out3_data, pv[3], hold);
         end
      end
      tests_run++;
      if (accepted < 10000) begin
         tests_failed++;
         $display("[TB] FAIL random_budget: accepted %0d expected 10000", accepted);
      end
      tests_run++;
      if (outputs != 39) begin
         tests_failed++;
         $display("[TB] FAIL random_output_count: got %0d expected 39", outputs);
      end
   endtask

   initial begin
      test_reset();
      test_rate4();
      test_back_to_back();
      test_rate_zero();
      test_gaps();
      test_rate_change();
      test_reset_midframe();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
